// File: rtl/quantdeser.sv
// Serial MSB-first capture of a quantized value, rebuilt into a parallel word.
// Received bits are re-placed at msbidx with optional sign fill above.
module quantdeser #(
  parameter int BDOUT   = 32,
  parameter int BDINMAX = 32,
  parameter int MAXBDOP = $clog2(BDOUT),
  parameter int MAXBDIP = $clog2(BDINMAX)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [MAXBDIP-1:0] bdin,
  input  logic [MAXBDOP-1:0] msbidx,
  input  logic               sgn,
  input  logic               din,
  output logic [BDOUT-1:0]   dout,
  output logic               valid,
  output logic               busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t               state, state_n;
  logic [BDINMAX-1:0]   acc, acc_n;
  logic [MAXBDIP-1:0]   cnt, cnt_n;
  logic [MAXBDIP-1:0]   bd_q, bd_c;
  logic [MAXBDOP-1:0]   msb_q, msb_c;
  logic                 sgn_q, sgn_c;
  logic                 done;
  logic                 fill;
  logic [BDOUT-1:0]     r, placed;
  int                   sh, top;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      bd_q  <= '0;
      msb_q <= '0;
      sgn_q <= 1'b0;
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      acc   <= acc_n;
      bd_q  <= bd_c;
      msb_q <= msb_c;
      sgn_q <= sgn_c;
      valid <= done;
      if (done) dout <= placed;
    end
  end

  // start wins in any state, so a new word aborts one in flight
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    bd_c    = bd_q;
    msb_c   = msb_q;
    sgn_c   = sgn_q;
    done    = 1'b0;
    if (start) begin
      bd_c     = bdin;
      msb_c    = msbidx;
      sgn_c    = sgn;
      acc_n    = '0;
      acc_n[0] = din;
      cnt_n    = bdin;
      if (bdin == '0) begin
        done    = 1'b1;
        state_n = IDLE;
      end else begin
        state_n = SHIFT;
      end
    end else begin
      unique case (state)
        IDLE: begin
          state_n = IDLE;
        end
        SHIFT: begin
          acc_n = {acc[BDINMAX-2:0], din};
          cnt_n = cnt - 1'b1;
          if (cnt <= MAXBDIP'(1)) begin
            done    = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // placement works on next-cycle values so a 1-bit word completes at once
  always_comb begin
    r = '0;
    for (int i = 0; i < BDINMAX; i++) begin
      if (i <= int'(bd_c)) r[i] = acc_n[i];
    end
    if (int'(msb_c) >= int'(bd_c)) begin
      sh  = int'(msb_c) - int'(bd_c);
      top = int'(msb_c);
    end else begin
      sh  = 0;
      top = int'(bd_c);
    end
    fill   = sgn_c & acc_n[bd_c];
    placed = r << sh;
    for (int i = 0; i < BDOUT; i++) begin
      if (i > top) placed[i] = fill;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_quantdeser.sv
// Bench for quantdeser: scoreboard of expected words and valid cycles,
// directed cases plus serializer-order loopback.
module tb_quantdeser;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  bdin = '0;
  logic [4:0]  msbidx = '0;
  logic        sgn = 1'b0;
  logic        din = 1'b0;
  logic [31:0] dout;
  logic        valid;
  logic        busy;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  quantdeser dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .bdin  (bdin),
    .msbidx(msbidx),
    .sgn   (sgn),
    .din   (din),
    .dout  (dout),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!clr && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid cyc=%0d dout=%h required no valid",
                 cyc, dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e.d || cyc != e.c) begin
          failures++;
          $display("FAIL word dout=%h cyc=%0d required dout=%h cyc=%0d",
                   dout, cyc, e.d, e.c);
        end
      end
    end
  end

  function automatic logic [31:0] model(int bd, int msb, logic sg,
                                        logic [31:0] w);
    logic [31:0] r;
    logic [31:0] o;
    int top;
    r = '0;
    for (int i = 0; i <= bd; i++) r[i] = w[i];
    if (msb >= bd) begin
      o   = r << (msb - bd);
      top = msb;
    end else begin
      o   = r;
      top = bd;
    end
    if (sg && r[bd])
      for (int i = top + 1; i < 32; i++) o[i] = 1'b1;
    return o;
  endfunction

  task automatic drive_bits(int bd, int msb, logic sg, logic [31:0] w, int n);
    for (int k = 0; k < n; k++) begin
      start  = (k == 0);
      bdin   = 5'(bd);
      msbidx = 5'(msb);
      sgn    = sg;
      din    = w[bd-k];
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    din   = 1'b0;
  endtask

  task automatic send(int bd, int msb, logic sg, logic [31:0] w);
    exp_t x;
    x.d = model(bd, msb, sg, w);
    x.c = cyc + bd + 1;
    exp_q.push_back(x);
    drive_bits(bd, msb, sg, w, bd + 1);
  endtask

  task automatic test_reset;
    clr = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (dout !== 32'h0 || valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset dout=%h valid=%b busy=%b required 0 0 0",
               dout, valid, busy);
    end
    clr = 1'b0;
    @(posedge clk);
    #1;
    send(0, 0, 1'b0, 32'h1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL one_bit_busy busy=%b required 0", busy);
    end
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_basic;
    send(1, 3, 1'b0, 32'h2);
    send(0, 31, 1'b0, 32'h1);
    send(5, 2, 1'b1, 32'h2C);
    send(5, 2, 1'b0, 32'h0C);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_full;
    fork
      send(31, 31, 1'b0, 32'h0000_0005);
      begin
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_mid busy=%b required 1", busy);
        end
      end
    join
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after busy=%b required 0", busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_sign;
    send(3, 7, 1'b1, 32'hB);
    send(3, 7, 1'b0, 32'hB);
    send(31, 31, 1'b1, 32'h8000_00F0);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sign_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_abort;
    drive_bits(7, 7, 1'b0, 32'hFF, 3);
    send(1, 1, 1'b0, 32'h3);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || dout !== 32'h3) begin
      failures++;
      $display("FAIL abort pending=%0d dout=%h required 0 and 00000003",
               exp_q.size(), dout);
    end
    drive_bits(7, 7, 1'b0, 32'hFF, 3);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checks++;
    if (dout !== 32'h0 || valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_mid dout=%h valid=%b busy=%b required 0 0 0",
               dout, valid, busy);
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (dout !== 32'h0) begin
      failures++;
      $display("FAIL clr_hold dout=%h required 00000000", dout);
    end
  endtask

  task automatic test_loopback;
    int          bdo;
    int          msb;
    logic [31:0] x;
    exp_t        ex;
    for (int t = 0; t < 200; t++) begin
      bdo = $urandom_range(32, 1);
      msb = $urandom_range(31, bdo - 1);
      x   = $urandom;
      ex.d = '0;
      for (int i = msb - bdo + 1; i <= msb; i++) ex.d[i] = x[i];
      ex.c = cyc + bdo;
      exp_q.push_back(ex);
      drive_bits(bdo - 1, msb, 1'b0, x >> (msb - bdo + 1), bdo);
    end
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL loop_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_full;
    test_sign;
    test_abort;
    test_loopback;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
